// File: rtl/dsd_tick_sched.sv
// rtl/dsd_tick_sched.sv - base-tick prescaler, NCH countdown channels, round-robin irq/ack arbiter
// Optional DSD_TICK_SCHED_TIMESTAMP_EN adds irq_ts_o, the base-tick count latched at each grant.
module dsd_tick_sched #(
  parameter int CLK_FREQ  = 50000000,
  parameter int TICK_HZ   = 30,
  parameter int PULSE_LEN = 30,
  parameter int NCH       = 4,
  localparam int CW       = $clog2(NCH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cfg_we_i,
  input  logic [CW-1:0]  cfg_ch_i,
  input  logic [7:0]     cfg_dat_i,
  output logic           tick_o,
  output logic           irq_o,
  output logic [CW-1:0]  irq_ch_o,
  input  logic           ack_i,
  output logic [NCH-1:0] overrun_o
`ifdef DSD_TICK_SCHED_TIMESTAMP_EN
  ,
  output logic [15:0]    irq_ts_o
`endif
);

  localparam logic [31:0] MAX_COUNT = 32'(CLK_FREQ / TICK_HZ);
  localparam logic [31:0] PULSE_CNT = 32'(PULSE_LEN);

  typedef enum logic {IDLE, GRANT} state_t;

  logic [31:0]   count_q;
  logic          tick_stb;
  state_t        state_q, state_d;
  logic [7:0]    reload_q [NCH];
  logic [7:0]    cnt_q [NCH];
  logic [NCH-1:0] pending_q;
  logic [NCH-1:0] wr_sel;
  logic [NCH-1:0] ack_sel;
  logic          granted_wr;
  logic          grant_ack;
  logic [CW-1:0] last_q, last_d;
  logic          irq_d;
  logic [CW-1:0] irq_ch_d;
  logic [CW-1:0] rr_sel;
  logic [CW-1:0] rr_cand;
  int            rr_j;

  assign tick_stb = (count_q == MAX_COUNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 32'd1;
      tick_o  <= 1'b0;
    end else if (tick_stb) begin
      count_q <= 32'd1;
      tick_o  <= 1'b1;
    end else begin
      count_q <= count_q + 32'd1;
      if (count_q == PULSE_CNT) begin
        tick_o <= 1'b0;
      end
    end
  end

  // A config write to the granted channel overrides a same-cycle ack.
  assign granted_wr = cfg_we_i && (cfg_ch_i == irq_ch_o);
  assign grant_ack  = (state_q == GRANT) && ack_i && !granted_wr;

  always_comb begin
    wr_sel  = '0;
    ack_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i]  = cfg_we_i && (cfg_ch_i == CW'(i));
      ack_sel[i] = grant_ack && (irq_ch_o == CW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        reload_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      pending_q <= '0;
      overrun_o <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_sel[i]) begin
          reload_q[i]  <= cfg_dat_i;
          cnt_q[i]     <= cfg_dat_i;
          pending_q[i] <= 1'b0;
          overrun_o[i] <= 1'b0;
        end else if (tick_stb && (reload_q[i] != 8'd0) && (cnt_q[i] == 8'd1)) begin
          cnt_q[i]     <= reload_q[i];
          pending_q[i] <= 1'b1;
          if (pending_q[i] && !ack_sel[i]) begin
            overrun_o[i] <= 1'b1;
          end
        end else begin
          if (tick_stb && (reload_q[i] != 8'd0)) begin
            cnt_q[i] <= cnt_q[i] - 8'd1;
          end
          if (ack_sel[i]) begin
            pending_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Scan offsets from far to near so the nearest pending channel after last_q wins.
  always_comb begin
    rr_sel  = last_q;
    rr_cand = last_q;
    rr_j    = 0;
    for (int k = NCH; k >= 1; k--) begin
      rr_j = int'(last_q) + k;
      if (rr_j >= NCH) begin
        rr_j = rr_j - NCH;
      end
      rr_cand = CW'(rr_j);
      if (pending_q[rr_cand]) begin
        rr_sel = rr_cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_o;
    irq_ch_d = irq_ch_o;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d  = GRANT;
          irq_d    = 1'b1;
          irq_ch_d = rr_sel;
        end
      end
      GRANT: begin
        if (granted_wr) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end else if (ack_i) begin
          state_d = IDLE;
          irq_d   = 1'b0;
          last_d  = irq_ch_o;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      irq_o    <= 1'b0;
      irq_ch_o <= '0;
      last_q   <= CW'(NCH - 1);
    end else begin
      state_q  <= state_d;
      irq_o    <= irq_d;
      irq_ch_o <= irq_ch_d;
      last_q   <= last_d;
    end
  end

`ifdef DSD_TICK_SCHED_TIMESTAMP_EN
  logic [15:0] ts_cnt_q;
  logic        ts_latch;

  assign ts_latch = (state_q == IDLE) && (|pending_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt_q <= '0;
      irq_ts_o <= '0;
    end else begin
      if (tick_stb) begin
        ts_cnt_q <= ts_cnt_q + 16'd1;
      end
      if (ts_latch) begin
        irq_ts_o <= tick_stb ? ts_cnt_q + 16'd1 : ts_cnt_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dsd_tick_sched.sv
// tb/tb_dsd_tick_sched.sv - self-checking bench for dsd_tick_sched against a rule-level model
// Timestamp checks compile only with DSD_TICK_SCHED_TIMESTAMP_EN.
module tb_dsd_tick_sched;
  localparam int CLK_FREQ = 300;
  localparam int TICK_HZ  = 30;
  localparam int PULSE    = 3;
  localparam int NCH      = 4;
  localparam int CW       = 2;
  localparam int MAXC     = CLK_FREQ / TICK_HZ;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [CW-1:0]  cfg_ch = '0;
  logic [7:0]     cfg_dat = '0;
  logic           ack = 1'b0;
  logic           tick;
  logic           irq;
  logic [CW-1:0]  irq_ch;
  logic [NCH-1:0] ovr;
`ifdef DSD_TICK_SCHED_TIMESTAMP_EN
  logic [15:0]    irq_ts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int           e;
  int           m_reload [NCH];
  int           m_ticks [NCH];
  bit [NCH-1:0] m_pend;
  bit [NCH-1:0] m_ovr;
  bit           m_grant;
  int           m_gch;
  int           m_last;
  int           m_ts;
  int           m_irq_ts;

  dsd_tick_sched #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ),
    .PULSE_LEN(PULSE),
    .NCH      (NCH)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .cfg_we_i (cfg_we),
    .cfg_ch_i (cfg_ch),
    .cfg_dat_i(cfg_dat),
    .tick_o   (tick),
    .irq_o    (irq),
    .irq_ch_o (irq_ch),
    .ack_i    (ack),
    .overrun_o(ovr)
`ifdef DSD_TICK_SCHED_TIMESTAMP_EN
    ,
    .irq_ts_o (irq_ts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e        = 0;
    m_pend   = '0;
    m_ovr    = '0;
    m_grant  = 1'b0;
    m_gch    = 0;
    m_last   = NCH - 1;
    m_ts     = 0;
    m_irq_ts = 0;
    for (int i = 0; i < NCH; i++) begin
      m_reload[i] = 0;
      m_ticks[i]  = 0;
    end
  endtask

  // Channel i expires on every reload-th base tick since its last write.
  task automatic step();
    bit           tk;
    bit           ackc;
    bit           hit;
    bit [NCH-1:0] pold;
    int           sel;
    if (rst) begin
      model_reset();
    end else begin
      tk = ((e + 1) % MAXC) == 0;
      e++;
      if (tk) m_ts = (m_ts + 1) % 65536;
      pold = m_pend;
      for (int i = 0; i < NCH; i++) begin
        ackc = m_grant && ack && (m_gch == i) && !(cfg_we && int'(cfg_ch) == m_gch);
        if (cfg_we && int'(cfg_ch) == i) begin
          m_reload[i] = int'(cfg_dat);
          m_ticks[i]  = 0;
          m_pend[i]   = 1'b0;
          m_ovr[i]    = 1'b0;
        end else if (tk && m_reload[i] != 0) begin
          m_ticks[i]++;
          if (m_ticks[i] % m_reload[i] == 0) begin
            if (m_pend[i] && !ackc) m_ovr[i] = 1'b1;
            m_pend[i] = 1'b1;
          end else if (ackc) begin
            m_pend[i] = 1'b0;
          end
        end else if (ackc) begin
          m_pend[i] = 1'b0;
        end
      end
      if (!m_grant) begin
        if (pold != '0) begin
          hit = 1'b0;
          sel = 0;
          for (int k = 1; k <= NCH; k++) begin
            if (!hit && pold[(m_last + k) % NCH]) begin
              hit = 1'b1;
              sel = (m_last + k) % NCH;
            end
          end
          m_grant  = 1'b1;
          m_gch    = sel;
          m_irq_ts = m_ts;
        end
      end else if (cfg_we && int'(cfg_ch) == m_gch) begin
        m_grant = 1'b0;
      end else if (ack) begin
        m_grant = 1'b0;
        m_last  = m_gch;
      end
    end
    @(posedge clk);
    #1;
    check("tick_o", tick, (e >= MAXC) && (e % MAXC < PULSE));
    check("irq_o", irq, m_grant);
    check("irq_ch_o", irq_ch, m_gch);
    check("overrun_o", ovr, m_ovr);
`ifdef DSD_TICK_SCHED_TIMESTAMP_EN
    check("irq_ts_o", irq_ts, m_irq_ts);
`endif
  endtask

  task automatic cfg_write(input int ch, input int dat);
    cfg_we  = 1'b1;
    cfg_ch  = CW'(ch);
    cfg_dat = 8'(dat);
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic run(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      case (mode)
        0:       ack = 1'b0;
        1:       ack = m_grant;
        default: ack = m_grant ? 1'($urandom % 2) : ($urandom % 8 == 0);
      endcase
      step();
    end
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

`ifdef DSD_TICK_SCHED_TIMESTAMP_EN
  task automatic ts_run(input int n);
    int  prev;
    bit  was;
    prev = -1;
    for (int c = 0; c < n; c++) begin
      ack = m_grant;
      was = m_grant;
      step();
      if (!was && m_grant) begin
        if (prev >= 0) check("ts_delta", 32'(16'(irq_ts - 16'(prev))), 3);
        prev = int'(irq_ts);
      end
    end
    ack = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    run(35, 0);
    check("t1_no_irq", irq, 1'b0);

    cfg_write(1, 2);
    run(60, 1);

    do_reset();
    cfg_write(0, 1);
    cfg_write(2, 1);
    run(40, 1);

    do_reset();
    cfg_write(3, 1);
    run(25, 0);
    check("t4_overrun", ovr, 4'b1000);
    cfg_write(3, 1);
    check("t4_overrun_clr", ovr, 4'b0000);
    check("t4_irq_drop", irq, 1'b0);

    do_reset();
    cfg_write(1, 1);
    cfg_write(2, 1);
    run(25, 0);
    do_reset();
    check("t5_irq", irq, 1'b0);
    check("t5_ovr", ovr, 4'b0000);
    check("t5_tick", tick, 1'b0);
    run(40, 0);
    check("t5_no_grant", irq, 1'b0);

`ifdef DSD_TICK_SCHED_TIMESTAMP_EN
    do_reset();
    cfg_write(1, 3);
    ts_run(150);
    force dut.ts_cnt_q = 16'hFFFE;
    m_ts = 16'hFFFE;
    #2;
    release dut.ts_cnt_q;
    ts_run(150);
`endif

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom % 500 == 0);
      cfg_we  = ($urandom % 16 == 0);
      cfg_ch  = CW'($urandom % NCH);
      cfg_dat = 8'($urandom % 5);
      ack     = m_grant ? 1'($urandom % 2) : ($urandom % 8 == 0);
      step();
    end
    rst    = 1'b0;
    cfg_we = 1'b0;
    ack    = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
